// File: rtl/ex_div_seq_pkg.sv
// Shared encodings for the EX-stage divide sequencer: RV32M divide op codes
// (also decoded by id/ex) and the sequencer state encoding.
package ex_div_seq_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  function automatic logic op_is_signed(div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(div_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/ex_div_seq_div_step.sv
// One iteration of a restoring divide: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] q,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] q_nxt
);

  logic [XLEN-1:0] shifted;
  logic            fits;

  // The shifted remainder is XLEN+1 bits wide, so the fit test uses the full
  // width while the subtraction only needs the low XLEN bits of the result.
  assign shifted = {rem[XLEN-2:0], q[XLEN-1]};
  assign fits    = {rem, q[XLEN-1]} >= {1'b0, divisor};
  assign rem_nxt = fits ? (shifted - divisor) : shifted;
  assign q_nxt   = {q[XLEN-2:0], fits};

endmodule

// File: rtl/ex_div_seq.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer beside the EX ALU: stalls the pipe,
// runs XLEN restoring steps, then pulses ready_o with the fixed-up result.
module ex_div_seq
  import ex_div_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            annul_i,
  output logic            stallreq_o,
  output logic            ready_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state, state_nxt;
  div_op_e         op_in, op_q;
  logic            sign_a, sign_b;
  logic [XLEN-1:0] rem_q, quot_q, dsr_q;
  logic [XLEN-1:0] rem_nxt, quot_nxt;
  logic [CW-1:0]   cnt;

  logic            in_signed, accept, div_zero, overflow, special, last_step;
  logic [XLEN-1:0] abs_a, abs_b, special_res, q_fix, r_fix, fix_res;

  assign op_in     = div_op_e'(op_i);
  assign in_signed = op_is_signed(op_in);
  assign accept    = (state == S_IDLE) && start_i && !annul_i;
  assign abs_a     = (in_signed && dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
  assign abs_b     = (in_signed && divisor_i[XLEN-1])  ? -divisor_i  : divisor_i;

  // RISC-V defines fixed results for divide-by-zero and signed overflow, so
  // those bypass the iterative loop entirely.
  assign div_zero = (divisor_i == '0);
  assign overflow = in_signed && (dividend_i == MIN_INT) && (divisor_i == '1);
  assign special  = div_zero || overflow;
  always_comb begin
    special_res = '0;
    if (op_is_rem(op_in))
      special_res = div_zero ? dividend_i : '0;
    else
      special_res = div_zero ? '1 : MIN_INT;
  end

  div_step #(.XLEN(XLEN)) u_step (
    .rem     (rem_q),
    .q       (quot_q),
    .divisor (dsr_q),
    .rem_nxt (rem_nxt),
    .q_nxt   (quot_nxt)
  );

  assign last_step = (state == S_RUN) && (cnt == LAST_CNT);
  assign q_fix   = (op_is_signed(op_q) && (sign_a ^ sign_b)) ? -quot_nxt : quot_nxt;
  assign r_fix   = (op_is_signed(op_q) && sign_a) ? -rem_nxt : rem_nxt;
  assign fix_res = op_is_rem(op_q) ? r_fix : q_fix;

  assign stallreq_o = accept || (state == S_RUN);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = special ? S_DONE : S_RUN;
      S_RUN:   if (last_step) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (annul_i) state_nxt = S_IDLE;
  end

  // A flush freezes the datapath so result_o keeps its previous value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ready_o  <= 1'b0;
      result_o <= '0;
      cnt      <= '0;
      op_q     <= OP_DIV;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      rem_q    <= '0;
      quot_q   <= '0;
      dsr_q    <= '0;
    end else begin
      state   <= state_nxt;
      ready_o <= 1'b0;
      if (accept) begin
        op_q   <= op_in;
        sign_a <= in_signed && dividend_i[XLEN-1];
        sign_b <= in_signed && divisor_i[XLEN-1];
        dsr_q  <= abs_b;
        quot_q <= abs_a;
        rem_q  <= '0;
        cnt    <= '0;
        if (special) begin
          result_o <= special_res;
          ready_o  <= 1'b1;
        end
      end else if ((state == S_RUN) && !annul_i) begin
        rem_q  <= rem_nxt;
        quot_q <= quot_nxt;
        cnt    <= cnt + 1'b1;
        if (last_step) begin
          result_o <= fix_res;
          ready_o  <= 1'b1;
        end
      end
    end
  end

endmodule
